// File: rtl/tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_sched_pkg
// Description : Shared types and sizes for the transmit FIFO read scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_sched_pkg;

    localparam int LANES   = 4;
    localparam int LANE_W  = 8;
    localparam int USEDW_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        READ = 2'd2,
        GAP  = 2'd3
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/tx_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tx_rr_arb
// Description : Combinational 4-way round-robin picker. Returns the first
//               eligible lane at or after the pointer (ptr, ptr+1, ... mod 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tx_rr_arb
    import tx_sched_pkg::*;
(
    input  logic [LANES-1:0] elig_i,
    input  logic [1:0]       ptr_i,
    output logic [1:0]       grant_o,
    output logic             grant_vld_o
);

    logic [1:0] w_idx;

    // Scan from the farthest offset down so the nearest eligible lane wins.
    always_comb begin
        grant_o     = ptr_i;
        grant_vld_o = 1'b0;
        w_idx       = ptr_i;
        for (int k = LANES - 1; k >= 0; k--) begin
            w_idx = ptr_i + 2'(k);
            if (elig_i[w_idx]) begin
                grant_o     = w_idx;
                grant_vld_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_fifo_sched.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo_sched
// Description : Read-side scheduler for a four-lane 8-bit transmit FIFO bank.
//               Grants lanes round-robin, reads one fixed burst per grant,
//               serialises the bytes as a framed stream and sequences
//               per-lane aclr flushes around active bursts.
//               Optional macro TX_SCHED_TIMEOUT_EN enables partial-burst
//               age timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo_sched
    import tx_sched_pkg::*;
#(
    parameter int BURST_LEN   = 64,
    parameter int GAP_CYC     = 2,
    parameter int FLUSH_CYC   = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       rd_clk,
    input  logic                       rst_n,
    input  logic [LANES*USEDW_W-1:0]   rdusedw,
    input  logic [LANES*LANE_W-1:0]    q,
    output logic [LANES-1:0]           rdreq,
    output logic [LANES-1:0]           aclr,
    input  logic [LANES-1:0]           flush_req,
    input  logic                       tx_ready,
    output logic [LANE_W-1:0]          tx_data,
    output logic                       tx_valid,
    output logic                       tx_sof,
    output logic                       tx_eof,
    output logic [1:0]                 tx_lane,
    output logic                       busy
);

    localparam logic [USEDW_W-1:0] c_BURST = USEDW_W'(BURST_LEN);
    localparam logic [3:0]         c_GAP   = 4'(GAP_CYC);
    localparam logic [2:0]         c_FLUSH = 3'(FLUSH_CYC);

    generate
        if (BURST_LEN < 1 || BURST_LEN > 1023 || GAP_CYC < 1 || GAP_CYC > 15 ||
            FLUSH_CYC < 1 || FLUSH_CYC > 7 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 8191) begin : g_bad_cfg
            $error("tx_fifo_sched: parameter out of range");
        end
    endgenerate

    sched_state_e              state_q, state_d;
    logic [1:0]                lane_q, lane_d;
    logic [USEDW_W-1:0]        len_q, len_d;
    logic [USEDW_W-1:0]        cnt_q, cnt_d;
    logic [3:0]                gap_q, gap_d;
    logic [1:0]                ptr_q, ptr_d;
    logic [LANES-1:0]          pend_q, pend_d;
    logic [LANES-1:0][2:0]     fcnt_q, fcnt_d;
    logic [LANES-1:0]          aclr_prev_q;
    logic                      tx_valid_q, tx_sof_q, tx_eof_q;
    logic [1:0]                tx_lane_q;

    logic [USEDW_W-1:0]        w_usedw [LANES];
    logic [LANES-1:0]          w_full, w_timed, w_blocked, w_elig, w_take;
    logic [1:0]                w_grant;
    logic                      w_grant_vld;
    logic [USEDW_W-1:0]        w_len;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_usedw[i]   = rdusedw[USEDW_W*i +: USEDW_W];
            assign w_full[i]    = w_usedw[i] >= c_BURST;
            assign aclr[i]      = fcnt_q[i] != 3'd0;
            // A lane is held off while a flush is requested, pending or
            // running, and for the one cycle after its aclr falls.
            assign w_blocked[i] = pend_q[i] | flush_req[i] | aclr[i] |
                                  (aclr_prev_q[i] & ~aclr[i]);
            assign w_take[i]    = (state_q == ARB) && w_grant_vld && (w_grant == 2'(i));
        end
    endgenerate

    assign w_elig = (w_full | w_timed) & ~w_blocked;

`ifdef TX_SCHED_TIMEOUT_EN
    localparam logic [12:0] c_TIMEOUT = 13'(TIMEOUT_CYC);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_age
            logic [12:0] age_q;
            logic        w_partial;

            assign w_partial  = (w_usedw[i] != '0) && (w_usedw[i] < c_BURST);
            assign w_timed[i] = w_partial && (age_q >= c_TIMEOUT);

            // Age a partially filled lane; a grant or a flush restarts it.
            always_ff @(posedge rd_clk or negedge rst_n) begin
                if (!rst_n) begin
                    age_q <= '0;
                end else if (w_take[i] || aclr[i]) begin
                    age_q <= '0;
                end else if (w_partial && (age_q < c_TIMEOUT)) begin
                    age_q <= age_q + 13'd1;
                end
            end
        end
    endgenerate

    // A timed-out lane sends whatever it holds, capped at a full burst.
    assign w_len = (w_usedw[w_grant] < c_BURST) ? w_usedw[w_grant] : c_BURST;
`else
    assign w_timed = '0;
    assign w_len   = c_BURST;
`endif

    tx_rr_arb u_arb (
        .elig_i      (w_elig),
        .ptr_i       (ptr_q),
        .grant_o     (w_grant),
        .grant_vld_o (w_grant_vld)
    );

    // Scheduler next-state: arbitrate, read one burst, then pause.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if ((|w_elig) && tx_ready) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (w_grant_vld) begin
                    lane_d  = w_grant;
                    len_d   = w_len;
                    cnt_d   = w_len;
                    ptr_d   = w_grant + 2'd1;
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (cnt_q == 10'd1) begin
                    gap_d   = c_GAP;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            GAP: begin
                if (gap_q == 4'd1) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read request follows the registered state so reset drops it at once.
    always_comb begin
        rdreq = '0;
        if (state_q == READ) begin
            rdreq[lane_q] = 1'b1;
        end
    end

    // Flush sequencing: wait until the lane is not being read, then pulse aclr.
    always_comb begin
        pend_d = pend_q | flush_req;
        fcnt_d = fcnt_q;
        for (int i = 0; i < LANES; i++) begin
            if (fcnt_q[i] != 3'd0) begin
                fcnt_d[i] = fcnt_q[i] - 3'd1;
                if (fcnt_q[i] == 3'd1) begin
                    pend_d[i] = flush_req[i];
                end
            end else if (pend_q[i] && !rdreq[i]) begin
                fcnt_d[i] = c_FLUSH;
            end
        end
    end

    // Scheduler and flush state registers.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            ptr_q       <= '0;
            pend_q      <= '0;
            fcnt_q      <= '0;
            aclr_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            fcnt_q      <= fcnt_d;
            aclr_prev_q <= aclr;
        end
    end

    // Output framing: one stage behind rdreq, matching the FIFO read latency.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            tx_sof_q   <= 1'b0;
            tx_eof_q   <= 1'b0;
            tx_lane_q  <= '0;
        end else begin
            tx_valid_q <= (state_q == READ);
            tx_sof_q   <= (state_q == READ) && (cnt_q == len_q);
            tx_eof_q   <= (state_q == READ) && (cnt_q == 10'd1);
            if (state_q == READ) begin
                tx_lane_q <= lane_q;
            end
        end
    end

    // The FIFO's q is its own output register; selecting it with the
    // registered lane keeps each byte aligned with tx_valid.
    always_comb begin
        tx_data = '0;
        if (tx_valid_q) begin
            tx_data = q[{tx_lane_q, 3'b000} +: LANE_W];
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_sof   = tx_sof_q;
    assign tx_eof   = tx_eof_q;
    assign tx_lane  = tx_lane_q;
    assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_fifo_sched
// Description : Self-checking bench for tx_fifo_sched with a FIFO bank model,
//               a round-robin burst predictor and a byte-stream scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tx_fifo_sched;

    localparam int BL  = 64;
    localparam int GAP = 2;
    localparam int FL  = 2;
    localparam int TO  = 16;

    logic        rd_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [39:0] rdusedw;
    logic [31:0] q;
    logic [3:0]  rdreq, aclr;
    logic [3:0]  flush_req = '0;
    logic        tx_ready  = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_sof, tx_eof, busy;
    logic [1:0]  tx_lane;

    tx_fifo_sched #(.BURST_LEN(BL), .GAP_CYC(GAP), .FLUSH_CYC(FL), .TIMEOUT_CYC(TO)) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .rdusedw(rdusedw), .q(q), .rdreq(rdreq),
        .aclr(aclr), .flush_req(flush_req), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_lane(tx_lane),
        .busy(busy)
    );

    always #5 rd_clk = ~rd_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- FIFO bank model ----------------
    int unsigned wr_ptr [4] = '{default: 0};   // written by stimulus only
    int unsigned rd_ptr [4] = '{default: 0};   // written by the model only
    logic [7:0]  seed   [4];
    logic [7:0]  q_r    [4] = '{default: 8'h00};

    always @(posedge rd_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (aclr[i]) begin
                rd_ptr[i] <= wr_ptr[i];
            end else if (rdreq[i]) begin
                q_r[i]    <= seed[i] + 8'(rd_ptr[i]);
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        rdusedw = '0;
        q       = '0;
        for (int i = 0; i < 4; i++) begin
            rdusedw[10*i +: 10] = 10'(wr_ptr[i] - rd_ptr[i]);
            q[8*i +: 8]         = q_r[i];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int         lane;
        int         len;
        logic [7:0] first;
        int         gap;      // required sof-to-sof distance, 0 = unchecked
    } burst_t;

    burst_t exp_q[$];
    burst_t cur;
    int     idx      = 0;
    int     cyc      = 0;
    int     last_sof = 0;

    always @(negedge rd_clk) begin
        cyc++;
        if (!rst_n) begin
            idx = 0;
        end else begin
            chk($countones(rdreq) <= 1, "rdreq_onehot", int'(rdreq), 1);
            if (tx_valid) begin
                if (idx == 0) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_burst", int'(tx_lane), -1);
                        cur = '{lane: -1, len: 1, first: 8'h00, gap: 0};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    if (cur.gap != 0) chk(cyc - last_sof == cur.gap, "sof_spacing", cyc - last_sof, cur.gap);
                    last_sof = cyc;
                end
                chk(int'(tx_lane) == cur.lane, "tx_lane", int'(tx_lane), cur.lane);
                chk(tx_data == cur.first + 8'(idx), "tx_data", int'(tx_data), int'(cur.first + 8'(idx)));
                chk(tx_sof == (idx == 0), "tx_sof", int'(tx_sof), int'(idx == 0));
                chk(tx_eof == (idx == cur.len - 1), "tx_eof", int'(tx_eof), int'(idx == cur.len - 1));
                idx = (idx == cur.len - 1) ? 0 : idx + 1;
            end else begin
                chk(!tx_sof && !tx_eof, "framing_idle", int'({tx_sof, tx_eof}), 0);
            end
        end
    end

    // ---------------- reference model ----------------
    int unsigned head [4] = '{default: 0};   // next byte index the scheduler should read
    int          mptr     = 0;

    task automatic tick();
        @(negedge rd_clk);
    endtask

    task automatic write(input int lane, input int n);
        wr_ptr[lane] = wr_ptr[lane] + n;
    endtask

    task automatic push(input int lane, input int len, input int gap);
        exp_q.push_back('{lane: lane, len: len, first: seed[lane] + 8'(head[lane]), gap: gap});
        head[lane] = head[lane] + len;
        mptr       = (lane + 1) % 4;
    endtask

    // Predict the grant sequence for the bytes now queued, all eligible at once.
    task automatic predict();
        int  rem [4];
        bit  first = 1'b1;
        bit  found;
        for (int i = 0; i < 4; i++) rem[i] = int'(wr_ptr[i] - head[i]);
        do begin
            found = 1'b0;
            for (int k = 0; k < 4 && !found; k++) begin
                if (rem[(mptr + k) % 4] >= BL) begin
                    int j = (mptr + k) % 4;
                    found  = 1'b1;
                    rem[j] = rem[j] - BL;
                    push(j, BL, first ? 0 : BL + GAP + 2);
                    first = 1'b0;
                end
            end
        end while (found);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (!(exp_q.size() == 0 && idx == 0 && !busy) && n < bound) begin
            tick();
            n++;
        end
        chk(n < bound, "drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_bytes(input int nb, input int bound);
        int seen = 0;
        int n    = 0;
        while (seen < nb && n < bound) begin
            tick();
            n++;
            if (tx_valid) seen++;
        end
        chk(seen == nb, "byte_wait_timeout", seen, nb);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 4; i++) seed[i] = 8'($urandom);

        // Reset state
        repeat (3) tick();
        chk(rdreq == 4'b0, "rst_rdreq", int'(rdreq), 0);
        chk(aclr == 4'b0, "rst_aclr", int'(aclr), 0);
        chk(!tx_valid && !tx_sof && !tx_eof, "rst_tx_flags", int'({tx_valid, tx_sof, tx_eof}), 0);
        chk(tx_data == 8'h00 && tx_lane == 2'd0, "rst_tx_data_lane", int'({tx_lane, tx_data}), 0);
        chk(!busy, "rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // All lanes deep: strict 0,1,2,3,0,... order with fixed sof spacing
        for (int i = 0; i < 4; i++) write(i, 2 * BL);
        predict();
        tx_ready = 1'b1;
        wait_drain(2000);

        // Lane 2 alone, exactly one burst
        write(2, BL);
        predict();
        wait_drain(500);

        // Randomised fill patterns
        repeat (4) begin
            int total = 0;
            tx_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                int k = int'($urandom_range(0, 2));
                write(i, k * BL);
                total += k;
            end
            if (total == 0) write(int'($urandom_range(0, 3)), BL);
            predict();
            repeat ($urandom_range(0, 5)) tick();
            tx_ready = 1'b1;
            wait_drain(3000);
        end

        // tx_ready gating: eligible lane waits, then starts two cycles later
        tx_ready = 1'b0;
        write(0, BL);
        predict();
        repeat (6) begin
            tick();
            chk(rdreq == 4'b0, "noready_rdreq", int'(rdreq), 0);
            chk(!busy, "noready_busy", int'(busy), 0);
        end
        tx_ready = 1'b1;
        tick();
        chk(rdreq == 4'b0, "ready_lat1_rdreq", int'(rdreq), 0);
        tick();
        chk(rdreq == 4'b0001, "ready_lat2_rdreq", int'(rdreq), 1);
        wait_drain(500);

        // Flush during own burst: deferred until after tx_eof
        write(1, 2 * BL);
        push(1, BL, 0);
        wait_bytes(10, 300);
        flush_req = 4'b0010;
        begin
            int n = 0;
            bit eof_seen = 1'b0;
            while (!eof_seen && n < 200) begin
                tick();
                flush_req = 4'b0000;
                n++;
                chk(aclr[1] == 1'b0, "aclr_during_burst", int'(aclr[1]), 0);
                eof_seen = tx_eof;
            end
            chk(eof_seen, "flush_eof_timeout", int'(eof_seen), 1);
        end
        tick();
        chk(aclr == 4'b0010, "aclr_cycle1", int'(aclr), 2);
        tick();
        chk(aclr == 4'b0010, "aclr_cycle2", int'(aclr), 2);
        tick();
        chk(aclr == 4'b0000, "aclr_released", int'(aclr), 0);
        head[1] = wr_ptr[1];
        write(1, BL);
        push(1, BL, 0);
        chk(rdreq == 4'b0, "regrant_c0", int'(rdreq), 0);
        tick();
        chk(rdreq == 4'b0, "regrant_c1", int'(rdreq), 0);
        tick();
        chk(rdreq == 4'b0, "regrant_c2", int'(rdreq), 0);
        tick();
        chk(rdreq == 4'b0010, "regrant_c3", int'(rdreq), 2);
        wait_drain(500);

        // Partial fill on lane 3
        write(3, 5);
`ifdef TX_SCHED_TIMEOUT_EN
        push(3, 5, 0);
        wait_drain(300);
`else
        repeat (60) begin
            tick();
            chk(rdreq == 4'b0, "partial_no_burst", int'(rdreq), 0);
        end
`endif

        // Reset in mid-burst
        write(0, 2 * BL);
        push(0, BL, 0);
        wait_bytes(30, 300);
        rst_n = 1'b0;
        #1;
        chk(rdreq == 4'b0, "midrst_rdreq", int'(rdreq), 0);
        chk(!tx_valid && !tx_eof, "midrst_tx", int'({tx_valid, tx_eof}), 0);
        chk(!busy, "midrst_busy", int'(busy), 0);
        exp_q.delete();
        head[0] = head[0] - BL + 30;
        mptr    = 0;
        tx_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk(!busy, "postrst_busy", int'(busy), 0);
        write(0, 30);
        for (int i = 1; i < 4; i++) write(i, BL);
        predict();
        tx_ready = 1'b1;
        wait_drain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
